shared_bus_switch: RTL
======================

# shared_bus_switch

Parametrised successor to the cluster's fixed 16-core shared-memory mux. It arbitrates N core ports onto one shared global-memory port and one memory-mapped device window. Arbitration is selectable between a static rotating slot and request-driven round-robin. It adds bus locking for read-modify-write sequences and a per-port one-hot read-return strobe. It sits between the core array and the global SRAM / device bus inside the cluster.

## Interface
- NUM_PORTS, 16, number of core ports (2..32)
- DATA_WIDTH, 16, shared data word width
- ADDR_WIDTH, 16, shared address width
- DEV_ADDR_WIDTH, 10, device window offset width; window = addr[ADDR_WIDTH-1:DEV_ADDR_WIDTH] all ones
- ARB_MODE, 0, 0 = round-robin on requests, 1 = static rotation every cycle
- MAX_LOCK, 8, max consecutive cycles one port may hold the bus via lock
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- port_wren  in  NUM_PORTS  per-port write request
- port_rden  in  NUM_PORTS  per-port read request
- port_lock  in  NUM_PORTS  request to retain grant next cycle
- port_addr  in  NUM_PORTS*ADDR_WIDTH  packed, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- port_wdata  in  NUM_PORTS*DATA_WIDTH  packed likewise
- port_ready  out  NUM_PORTS  one-hot grant; request of port i is accepted when port_ready[i]
- port_rvalid  out  NUM_PORTS  one-hot, read data for port i valid on read_data
- read_data  out  DATA_WIDTH  broadcast read return
- gmem_addr  out  ADDR_WIDTH  global memory address
- gmem_we  out  1  global memory write enable
- gmem_wdata  out  DATA_WIDTH  global memory write data
- gmem_q  in  DATA_WIDTH  global memory read data, 1-cycle latency
- device_port_id  out  $clog2(NUM_PORTS)  granted port index
- device_write_en, device_read_en  out  1  device strobes
- device_addr  out  DEV_ADDR_WIDTH  device offset
- device_data_out  out  DATA_WIDTH  = gmem_wdata
- device_data_in  in  DATA_WIDTH  device read data, 1-cycle latency

## Operation
- Granted port g muxes wren/rden/addr/wdata onto the shared side. dev_sel = window match on addr. gmem_we = wren & !dev_sel. device_write_en = wren & dev_sel. device_read_en = rden & dev_sel.
- Round-robin (ARB_MODE 0): port_ready is combinational from requests (wren|rden) and a registered priority pointer ptr. Lowest-index requester at or above ptr wins, with wrap. If no requests, port_ready = 0 and the shared side is idle (we/rd strobes 0). After a granted cycle, ptr <= g+1 mod NUM_PORTS.
- Static (ARB_MODE 1): port_ready is a registered one-hot rotating left each cycle regardless of requests. Lock is ignored.
- Lock: if the granted port has port_lock set, is requesting, and lock_cnt < MAX_LOCK-1, it is granted again next cycle and ptr does not advance. lock_cnt counts consecutive locked regrants. It clears when the grant moves or goes idle. On reaching the limit, the lock is ignored for one arbitration and normal round-robin resumes.
- Read return: port_rvalid <= port_ready & port_rden (registered). dev_sel_l <= dev_sel. read_data = dev_sel_l ? device_data_in : gmem_q.
- Simultaneous write+read from one port: treated as a write; no rvalid.

## Timing
- Request to grant: 0 cycles (same cycle) in mode 0, provided the port wins.
- Read grant cycle N -> port_rvalid/read_data at N+1, one cycle only.
- Back-to-back grants to different ports are allowed every cycle. Read returns pipeline one per cycle.
- Reset state: ptr = 0, static one-hot = 1 (port 0), lock_cnt = 0, port_rvalid = 0, dev_sel_l = 0.
- Reset asserted mid-lock or with a read in flight clears all state at the next edge; the pending rvalid is dropped.
- Ports must hold requests stable until port_ready.

## Structure
- Package shared_bus_pkg: ARB_RR/ARB_STATIC constants and the device-window match function.
- Sub-module rr_arbiter (NUM_PORTS, MAX_LOCK): ptr, lock counter, grant_oh. Mode 1 rotation stays in the top.
- Index encode of grant for device_port_id and the mux are done in the top via loops over packed vectors.

## Test plan
- Ports 0, 3 and 7 hold reads continuously -> grants cycle 0, 3, 7, 0, ... with exactly one port_rvalid per cycle one cycle later, and correct gmem data per port.
- Port 5 writes 0xBEEF to 0x0012, then reads it -> gmem_we on the write cycle; read_data = 0xBEEF with port_rvalid[5] one cycle after the read grant.
- Port 2 reads 0xFC05 with device_data_in = 0x1234 -> device_read_en = 1, device_addr = 0x005, device_port_id = 2, gmem_we = 0; read_data = 0x1234 next cycle.
- Port 1 locks with port 4 also requesting, MAX_LOCK = 8 -> port 1 holds the grant 8 consecutive cycles, then port 4 is granted.
- ARB_MODE 1, no requests -> port_ready rotates 1, 2, 4, ... and wraps after NUM_PORTS cycles.
- Reset asserted the cycle after a read grant -> no port_rvalid; the next grant starts from port 0.

Source files
------------

// File: rtl/shared_bus_switch_pkg.sv
// Shared definitions for the core-to-global-memory switch: arbitration modes and device window decode.
// Latency: none (constants and a pure combinational helper).
// Backpressure: not applicable.
package shared_bus_pkg;

  localparam int ARB_RR     = 0;
  localparam int ARB_STATIC = 1;

  // Widest address the window decode helper accepts.
  localparam int MAX_ADDR_BITS = 64;

  // True when every bit of addr[addr_w-1:dev_w] is set, i.e. the access targets the device window.
  function automatic logic dev_window_hit(input logic [MAX_ADDR_BITS-1:0] addr,
                                          input int addr_w,
                                          input int dev_w);
    logic hit;
    hit = 1'b1;
    for (int b = 0; b < MAX_ADDR_BITS; b++) begin
      if (b >= dev_w && b < addr_w && !addr[b]) hit = 1'b0;
    end
    return hit;
  endfunction

endpackage

// File: rtl/shared_bus_switch_if.sv
// Core-side bundle of the shared bus switch: per-port requests in, one-hot grant and read return out.
// Latency: wires only; grant is combinational, read return arrives one cycle after the grant.
// Backpressure: a port holds its request stable until its port_ready bit is seen high.
interface shared_bus_switch_if #(
  parameter int NUM_PORTS  = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);

  logic [NUM_PORTS-1:0]            port_wren;
  logic [NUM_PORTS-1:0]            port_rden;
  logic [NUM_PORTS-1:0]            port_lock;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata;
  logic [NUM_PORTS-1:0]            port_ready;
  logic [NUM_PORTS-1:0]            port_rvalid;
  logic [DATA_WIDTH-1:0]           read_data;

  // Core array side.
  modport master (
    output port_wren, port_rden, port_lock, port_addr, port_wdata,
    input  port_ready, port_rvalid, read_data
  );

  // Switch side.
  modport slave (
    input  port_wren, port_rden, port_lock, port_addr, port_wdata,
    output port_ready, port_rvalid, read_data
  );

endinterface

// File: rtl/shared_bus_switch_rr_arbiter.sv
// Request-driven round-robin arbiter with bounded bus locking for read-modify-write sequences.
// Latency: grant is combinational from req in the same cycle; pointer and lock state update at the edge.
// Backpressure: losers simply see no grant and keep requesting; a lock holder is cut off after MAX_LOCK cycles.
module rr_arbiter #(
  parameter int NUM_PORTS = 16,
  parameter int MAX_LOCK  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] lock,
  output logic [NUM_PORTS-1:0] grant_oh
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(MAX_LOCK - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PORTS - 1);

  logic [IDX_W-1:0] ptr;
  logic             lock_hold;
  logic [IDX_W-1:0] lock_idx;
  logic [CNT_W-1:0] lock_cnt;

  logic [IDX_W-1:0] rr_idx;
  logic             rr_found;
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  logic             lock_take;
  logic             lock_next;
  logic [IDX_W-1:0] scan_idx;
  int               scan;

  // Pick the winner: a still-requesting lock holder first, else the first requester at or after ptr.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    scan     = 0;
    scan_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan = int'(ptr) + k;
      if (scan >= NUM_PORTS) scan = scan - NUM_PORTS;
      scan_idx = IDX_W'(scan);
      if (!rr_found && req[scan_idx]) begin
        rr_found = 1'b1;
        rr_idx   = scan_idx;
      end
    end
    lock_take = lock_hold && req[lock_idx];
    win_idx   = lock_take ? lock_idx : rr_idx;
    win_vld   = lock_take || rr_found;
    lock_next = win_vld && lock[win_idx] && (lock_cnt < LOCK_LIMIT);
    grant_oh  = '0;
    if (win_vld) grant_oh[win_idx] = 1'b1;
  end

  // Advance the priority pointer past the winner, or freeze it while the winner keeps its lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      lock_hold <= 1'b0;
      lock_idx  <= '0;
      lock_cnt  <= '0;
    end else if (lock_next) begin
      lock_hold <= 1'b1;
      lock_idx  <= win_idx;
      lock_cnt  <= lock_cnt + CNT_W'(1);
    end else begin
      lock_hold <= 1'b0;
      lock_cnt  <= '0;
      if (win_vld) ptr <= (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/shared_bus_switch.sv
// Arbitrates N core ports onto one global-memory port and one memory-mapped device window.
// Latency: grant and shared-side strobes in the request cycle; read data and port_rvalid one cycle later.
// Backpressure: ungranted ports see port_ready low and must hold their request; read returns cannot stall.
module shared_bus_switch
  import shared_bus_pkg::*;
#(
  parameter int NUM_PORTS      = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int DEV_ADDR_WIDTH = 10,
  parameter int ARB_MODE       = 0,
  parameter int MAX_LOCK       = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  shared_bus_switch_if.slave           cores,
  output logic [ADDR_WIDTH-1:0]        gmem_addr,
  output logic                         gmem_we,
  output logic [DATA_WIDTH-1:0]        gmem_wdata,
  input  logic [DATA_WIDTH-1:0]        gmem_q,
  output logic [$clog2(NUM_PORTS)-1:0] device_port_id,
  output logic                         device_write_en,
  output logic                         device_read_en,
  output logic [DEV_ADDR_WIDTH-1:0]    device_addr,
  output logic [DATA_WIDTH-1:0]        device_data_out,
  input  logic [DATA_WIDTH-1:0]        device_data_in
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  arb_req;
  logic [NUM_PORTS-1:0]  arb_lock;
  logic [NUM_PORTS-1:0]  arb_grant;
  logic [NUM_PORTS-1:0]  rot_oh;
  logic [NUM_PORTS-1:0]  grant;
  logic [NUM_PORTS-1:0]  rvalid_q;
  logic                  dev_sel;
  logic                  dev_sel_l;
  logic                  sel_wren;
  logic                  sel_rden;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [IDX_W-1:0]      g_idx;

  assign req = cores.port_wren | cores.port_rden;

  // In static mode the arbiter sees no traffic and lock has no effect.
  assign arb_req  = (ARB_MODE == ARB_STATIC) ? '0 : req;
  assign arb_lock = (ARB_MODE == ARB_STATIC) ? '0 : cores.port_lock;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .MAX_LOCK  (MAX_LOCK)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (arb_req),
    .lock     (arb_lock),
    .grant_oh (arb_grant)
  );

  // Static slot: one-hot token rotating left every cycle regardless of requests.
  always_ff @(posedge clk) begin
    if (reset) rot_oh <= NUM_PORTS'(1);
    else       rot_oh <= {rot_oh[NUM_PORTS-2:0], rot_oh[NUM_PORTS-1]};
  end

  assign grant            = (ARB_MODE == ARB_STATIC) ? rot_oh : arb_grant;
  assign cores.port_ready = grant;

  // One-hot AND-OR mux of the granted port onto the shared side, plus index encode.
  always_comb begin
    sel_wren  = 1'b0;
    sel_rden  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    g_idx     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        sel_wren  = sel_wren  | cores.port_wren[i];
        sel_rden  = sel_rden  | cores.port_rden[i];
        sel_addr  = sel_addr  | cores.port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = sel_wdata | cores.port_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        g_idx     = g_idx     | IDX_W'(i);
      end
    end
  end

  assign dev_sel = dev_window_hit(MAX_ADDR_BITS'(sel_addr), ADDR_WIDTH, DEV_ADDR_WIDTH);

  // A combined write+read is a write, so the read strobe is masked by wren.
  assign gmem_addr       = sel_addr;
  assign gmem_we         = sel_wren & ~dev_sel;
  assign gmem_wdata      = sel_wdata;
  assign device_port_id  = g_idx;
  assign device_write_en = sel_wren & dev_sel;
  assign device_read_en  = sel_rden & ~sel_wren & dev_sel;
  assign device_addr     = sel_addr[DEV_ADDR_WIDTH-1:0];
  assign device_data_out = sel_wdata;

  // Track which granted reads return next cycle and from which source.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q  <= '0;
      dev_sel_l <= 1'b0;
    end else begin
      rvalid_q  <= grant & cores.port_rden & ~cores.port_wren;
      dev_sel_l <= dev_sel;
    end
  end

  assign cores.port_rvalid = rvalid_q;
  assign cores.read_data   = dev_sel_l ? device_data_in : gmem_q;

endmodule
